// File: rtl/mag_comp_min_tracker_pkg.sv
// Shared types for the streaming minimum tracker.
package mag_comp_min_tracker_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/mag_comp_cla_param.sv
// Unsigned magnitude comparator: out_cp = (in_a > in_b), out_eq = (in_a == in_b).
module mag_comp_cla_param #(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_cp,
  output logic              out_eq
);

  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] eqb;
  logic              gt_acc;
  logic              eq_acc;

  assign gen = in_a & ~in_b;
  assign eqb = ~(in_a ^ in_b);

  // Prefix from the MSB: a bit decides "greater" only if every higher bit is equal.
  always_comb begin
    gt_acc = 1'b0;
    eq_acc = 1'b1;
    for (int unsigned k = 0; k < DATA_W; k++) begin
      gt_acc = gt_acc | (eq_acc & gen[DATA_W-1-k]);
      eq_acc = eq_acc & eqb[DATA_W-1-k];
    end
    out_cp = gt_acc;
    out_eq = eq_acc;
  end

endmodule

// File: rtl/mag_comp_min_tracker.sv
// Streaming running-minimum finder with frame control and a held result handshake.
module mag_comp_min_tracker #(
  parameter int DATA_W         = 3,
  parameter int IDX_W          = 8,
  parameter int TIE_KEEP_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_ovf
);
  import mag_comp_min_tracker_pkg::*;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [DATA_W-1:0] min_q;
  logic [IDX_W-1:0]  idx_q;
  logic              ovf_q;
  logic              first_q;
  logic              accept;
  logic              min_gt;
  logic              min_eq;
  logic              take;

  mag_comp_cla_param #(.DATA_W(DATA_W)) u_cmp (
    .in_a   (min_q),
    .in_b   (in_data),
    .out_cp (min_gt),
    .out_eq (min_eq)
  );

  assign accept = in_valid && in_ready;
  assign take   = first_q | min_gt | (min_eq & (TIE_KEEP_FIRST == 0));

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && in_last) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      min_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= in_last ? '0 : cnt_q + IDX_W'(1);
        first_q <= in_last;
        // A non-first beat arriving at index 0 means the counter has wrapped.
        if (first_q)            ovf_q <= 1'b0;
        else if (cnt_q == '0)   ovf_q <= 1'b1;
        if (take) begin
          min_q <= in_data;
          idx_q <= cnt_q;
        end
      end
    end
  end

  assign out_min = min_q;
  assign out_idx = idx_q;
  assign out_ovf = ovf_q;

endmodule

// File: tb/tb_mag_comp_min_tracker.sv
// Randomized self-checking bench: three tracker configurations share one stimulus stream.
module tb_mag_comp_min_tracker;
  localparam int DW   = 3;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_last, out_ready;
  logic [DW-1:0] in_data;
  logic          in_ready  [NDUT];
  logic          out_valid [NDUT];
  logic          out_ovf   [NDUT];
  logic [DW-1:0] out_min   [NDUT];
  logic [7:0]    out_idx   [NDUT];
  logic [1:0]    idx_c;
  logic [DW-1:0] cmp_a, cmp_b;
  logic          cmp_gt, cmp_eq;

  int tie_first [NDUT] = '{1, 0, 1};
  int idx_w     [NDUT] = '{8, 8, 2};
  int checks = 0;
  int errors = 0;

  assign out_idx[2] = {6'd0, idx_c};

  mag_comp_min_tracker #(.DATA_W(DW), .IDX_W(8), .TIE_KEEP_FIRST(1)) dut_first (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid[0]), .out_ready(out_ready),
    .out_min(out_min[0]), .out_idx(out_idx[0]), .out_ovf(out_ovf[0]));

  mag_comp_min_tracker #(.DATA_W(DW), .IDX_W(8), .TIE_KEEP_FIRST(0)) dut_last (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid[1]), .out_ready(out_ready),
    .out_min(out_min[1]), .out_idx(out_idx[1]), .out_ovf(out_ovf[1]));

  mag_comp_min_tracker #(.DATA_W(DW), .IDX_W(2), .TIE_KEEP_FIRST(1)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid[2]), .out_ready(out_ready),
    .out_min(out_min[2]), .out_idx(idx_c), .out_ovf(out_ovf[2]));

  mag_comp_cla_param #(.DATA_W(DW)) u_cmp (
    .in_a(cmp_a), .in_b(cmp_b), .out_cp(cmp_gt), .out_eq(cmp_eq));

  // Reference: smallest value, its first (or last) position modulo 2^IDX_W, overflow if too long.
  function automatic void model(input int vals[$], input int tf, input int iw,
                                output int mn, output int ix, output int ov);
    int pos;
    mn = vals[0];
    foreach (vals[p]) if (vals[p] < mn) mn = vals[p];
    pos = -1;
    foreach (vals[p]) if (vals[p] == mn && (pos < 0 || tf == 0)) pos = p;
    ix = pos % (1 << iw);
    ov = (vals.size() > (1 << iw)) ? 1 : 0;
  endfunction

  task automatic send_frame(input int vals[$], input int max_gap);
    for (int p = 0; p < vals.size(); p++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_last  = 1'($urandom);
        in_data  = DW'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = DW'(vals[p]);
      in_last  = (p == vals.size() - 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic consume(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL %s_release dut%0d valid/ready got %0b/%0b want 0/1", name, d, out_valid[d], in_ready[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
    cmp_a = '0; cmp_b = '0;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_min[d] !== '0 ||
          out_idx[d] !== 8'd0 || out_ovf[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d rdy=%0b vld=%0b min=%0d idx=%0d ovf=%0b want 1 0 0 0 0",
                 d, in_ready[d], out_valid[d], out_min[d], out_idx[d], out_ovf[d]);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_tie_rule();
    int v[$];
    int mn, ix, ov;
    v.push_back(5); v.push_back(3); v.push_back(6); v.push_back(3);
    send_frame(v, 0);
    for (int d = 0; d < NDUT; d++) begin
      model(v, tie_first[d], idx_w[d], mn, ix, ov);
      checks++;
      if (out_valid[d] !== 1'b1 || out_min[d] !== DW'(mn) || out_idx[d] !== 8'(ix) || out_ovf[d] !== 1'(ov)) begin
        errors++;
        $display("FAIL tie_rule dut%0d got vld=%0b min=%0d idx=%0d ovf=%0b want 1 %0d %0d %0d",
                 d, out_valid[d], out_min[d], out_idx[d], out_ovf[d], mn, ix, ov);
      end
    end
    consume("tie_rule");
  endtask

  task automatic test_hold_stable();
    int v[$];
    v.push_back(7);
    send_frame(v, 0);
    for (int c = 0; c < 5; c++) begin
      for (int d = 0; d < NDUT; d++) begin
        checks++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || out_min[d] !== 3'd7 || out_idx[d] !== 8'd0) begin
          errors++;
          $display("FAIL hold_stable c%0d dut%0d got vld=%0b rdy=%0b min=%0d idx=%0d want 1 0 7 0",
                   c, d, out_valid[d], in_ready[d], out_min[d], out_idx[d]);
        end
      end
      @(posedge clk); #1;
    end
    consume("hold_stable");
  endtask

  task automatic test_wrap_ovf();
    int v[$];
    int mn, ix, ov;
    v.push_back(4); v.push_back(4); v.push_back(4); v.push_back(4); v.push_back(1); v.push_back(4);
    send_frame(v, 1);
    for (int d = 0; d < NDUT; d++) begin
      model(v, tie_first[d], idx_w[d], mn, ix, ov);
      checks++;
      if (out_valid[d] !== 1'b1 || out_min[d] !== DW'(mn) || out_idx[d] !== 8'(ix) || out_ovf[d] !== 1'(ov)) begin
        errors++;
        $display("FAIL wrap_ovf dut%0d got vld=%0b min=%0d idx=%0d ovf=%0b want 1 %0d %0d %0d",
                 d, out_valid[d], out_min[d], out_idx[d], out_ovf[d], mn, ix, ov);
      end
    end
    consume("wrap_ovf");
  endtask

  task automatic test_reset_mid_frame();
    int v[$];
    int mn, ix, ov;
    in_valid = 1'b1; in_last = 1'b0;
    in_data = 3'd2; @(posedge clk); #1;
    in_data = 3'd0; @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (out_valid[d] !== 1'b0 || out_min[d] !== '0 || in_ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid dut%0d got vld=%0b min=%0d rdy=%0b want 0 0 1", d, out_valid[d], out_min[d], in_ready[d]);
      end
    end
    v.push_back(6); v.push_back(5);
    send_frame(v, 2);
    for (int d = 0; d < NDUT; d++) begin
      model(v, tie_first[d], idx_w[d], mn, ix, ov);
      checks++;
      if (out_valid[d] !== 1'b1 || out_min[d] !== DW'(mn) || out_idx[d] !== 8'(ix) || out_ovf[d] !== 1'(ov)) begin
        errors++;
        $display("FAIL reset_mid_result dut%0d got vld=%0b min=%0d idx=%0d ovf=%0b want 1 %0d %0d %0d",
                 d, out_valid[d], out_min[d], out_idx[d], out_ovf[d], mn, ix, ov);
      end
    end
    consume("reset_mid");
  endtask

  task automatic test_back_to_back();
    int v[$];
    int mn, ix, ov;
    v.push_back(6);
    send_frame(v, 0);
    // A beat offered while the result is held must be ignored.
    in_valid = 1'b1; in_data = 3'd0; in_last = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    v.delete();
    v.push_back(5); v.push_back(6);
    send_frame(v, 0);
    for (int d = 0; d < NDUT; d++) begin
      model(v, tie_first[d], idx_w[d], mn, ix, ov);
      checks++;
      if (out_valid[d] !== 1'b1 || out_min[d] !== DW'(mn) || out_idx[d] !== 8'(ix) || out_ovf[d] !== 1'(ov)) begin
        errors++;
        $display("FAIL back_to_back dut%0d got vld=%0b min=%0d idx=%0d ovf=%0b want 1 %0d %0d %0d",
                 d, out_valid[d], out_min[d], out_idx[d], out_ovf[d], mn, ix, ov);
      end
    end
    consume("back_to_back");
  endtask

  task automatic test_comparator_sweep();
    int v[$];
    int mn, ix, ov;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        cmp_a = DW'(a); cmp_b = DW'(b);
        #1;
        checks++;
        if (cmp_gt !== (a > b) || cmp_eq !== (a == b)) begin
          errors++;
          $display("FAIL cmp a=%0d b=%0d got gt=%0b eq=%0b want %0b %0b", a, b, cmp_gt, cmp_eq, a > b, a == b);
        end
        v.delete();
        v.push_back(a); v.push_back(b);
        send_frame(v, 2);
        for (int d = 0; d < NDUT; d++) begin
          model(v, tie_first[d], idx_w[d], mn, ix, ov);
          checks++;
          if (out_valid[d] !== 1'b1 || out_min[d] !== DW'(mn) || out_idx[d] !== 8'(ix) || out_ovf[d] !== 1'(ov)) begin
            errors++;
            $display("FAIL sweep_min a=%0d b=%0d dut%0d got vld=%0b min=%0d idx=%0d want 1 %0d %0d",
                     a, b, d, out_valid[d], out_min[d], out_idx[d], mn, ix);
          end
        end
        consume("sweep");
      end
    end
  endtask

  task automatic test_random_frames();
    int v[$];
    int mn, ix, ov;
    for (int f = 0; f < 40; f++) begin
      v.delete();
      repeat ($urandom_range(1, 11)) v.push_back($urandom_range(0, 7));
      send_frame(v, 2);
      for (int d = 0; d < NDUT; d++) begin
        model(v, tie_first[d], idx_w[d], mn, ix, ov);
        checks++;
        if (out_valid[d] !== 1'b1 || out_min[d] !== DW'(mn) || out_idx[d] !== 8'(ix) || out_ovf[d] !== 1'(ov)) begin
          errors++;
          $display("FAIL random f%0d len%0d dut%0d got vld=%0b min=%0d idx=%0d ovf=%0b want 1 %0d %0d %0d",
                   f, v.size(), d, out_valid[d], out_min[d], out_idx[d], out_ovf[d], mn, ix, ov);
        end
      end
      consume("random");
    end
  endtask

  initial begin
    test_reset();
    test_tie_rule();
    test_hold_stable();
    test_wrap_ovf();
    test_reset_mid_frame();
    test_back_to_back();
    test_comparator_sweep();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
